// File: rtl/mips_fetch.sv
// mips_fetch: two-state MIPS instruction fetch stage with next-PC selection and exception redirect
// Parameters: RESET_PC (PC after reset), EXC_VECTOR (PC on exception or jr alignment fault)
// Ports:
//   clock, reset (async, active-low)
//   imem_req/imem_addr -> instruction memory, imem_ack/imem_rdata <- instruction memory
//   inst/inst_valid/opcode/funct -> decode, inst_ready/control_type/except/rs_data <- decode
//   pc, epc, align_fault -> status
// Build option: define MIPS_FETCH_ALIGN_CHECK_EN to trap misaligned jr targets to EXC_VECTOR
module mips_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  logic        inst_ready,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        align_fault
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      r_state, w_state;
  logic        r_run;
  logic [31:0] r_pc, r_inst, r_epc;
  logic [31:0] w_pc, w_inst, w_epc;
  logic [31:0] w_pc4, w_br, w_j, w_jr, w_target;
  logic        w_accept, w_misalign;
  // r_run keeps the request low until the first edge after reset release
  assign imem_req   = r_run && r_state == FETCH;
  assign imem_addr  = {r_pc[31:2], 2'b00};
  assign inst       = r_inst;
  assign inst_valid = r_state == HOLD;
  assign opcode     = r_inst[31:26];
  assign funct      = r_inst[5:0];
  assign pc         = r_pc;
  assign epc        = r_epc;
  assign w_accept   = r_state == HOLD && inst_ready;
  assign w_pc4      = r_pc + 32'd4;
  assign w_br       = w_pc4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_j        = {w_pc4[31:28], r_inst[25:0], 2'b00};
  assign w_jr       = rs_data & 32'hFFFF_FFFC;
  assign w_target   = control_type == 2'b00 ? w_pc4 :
                      control_type == 2'b01 ? w_br  :
                      control_type == 2'b10 ? w_j   : w_jr;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic r_align_fault;
  assign w_misalign  = control_type == 2'b11 && rs_data[1:0] != 2'b00;
  assign align_fault = r_align_fault;
  // a decoder exception outranks the alignment fault, so no pulse then
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_align_fault <= 1'b0;
    else        r_align_fault <= w_accept && w_misalign && !except;
`else
  assign w_misalign  = 1'b0;
  assign align_fault = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_inst  = r_inst;
    w_epc   = r_epc;
    if (r_state == FETCH) begin
      if (imem_req && imem_ack) begin
        w_inst  = imem_rdata;
        w_state = HOLD;
      end
    end else if (inst_ready) begin
      w_state = FETCH;
      w_pc    = except || w_misalign ? EXC_VECTOR : w_target;
      w_epc   = except || w_misalign ? r_pc : r_epc;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= FETCH;
      r_run   <= 1'b0;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_state;
      r_run   <= 1'b1;
      r_pc    <= w_pc;
      r_inst  <= w_inst;
      r_epc   <= w_epc;
    end
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: table-driven and randomized self-checking bench for mips_fetch
module tb_mips_fetch;
  localparam logic [31:0] RST = 32'h0040_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;
  logic        clock = 1'b0, reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic [31:0] inst, pc, epc, rs_data = 32'd0;
  logic        inst_valid, inst_ready = 1'b0, except = 1'b0, align_fault;
  logic [5:0]  opcode, funct;
  logic [1:0]  control_type = 2'b00;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_epc;
  logic        m_af;
  typedef struct {
    int          wt;
    logic [31:0] data;
    int          stall;
    logic [1:0]  ct;
    logic        ex;
    logic [31:0] rs;
    logic [31:0] pc_e;
    logic [31:0] epc_e;
    logic        af;
  } vec_t;
  vec_t v[12];
  mips_fetch dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .opcode(opcode), .funct(funct), .inst_ready(inst_ready), .control_type(control_type),
    .except(except), .rs_data(rs_data), .pc(pc), .epc(epc), .align_fault(align_fault)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // architectural next-PC rules, straight arithmetic on the accepted instruction
  task automatic model(input logic [31:0] ins, input logic [1:0] ct, input logic ex, input logic [31:0] rs);
    logic [31:0] p4;
    int off;
    p4 = m_pc + 32'd4;
    off = $signed(ins[15:0]);
    m_af = 1'b0;
    if (ex) begin
      m_epc = m_pc;
      m_pc = EXC;
    end else if (ct == 2'd0) m_pc = p4;
    else if (ct == 2'd1) m_pc = p4 + 32'(off * 4);
    else if (ct == 2'd2) m_pc = (p4 & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
    else begin
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
      if (rs % 4 != 0) begin
        m_epc = m_pc;
        m_pc = EXC;
        m_af = 1'b1;
      end else m_pc = rs;
`else
      m_pc = rs - rs % 4;
`endif
    end
  endtask
  // called at a negedge with the DUT in FETCH; returns at the negedge after acceptance
  task automatic run_instr(input int wt, input logic [31:0] data, input int stall,
                           input logic [1:0] ct, input logic ex, input logic [31:0] rs);
    for (int i = 0; i <= wt; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_valid", inst_valid, 0);
      chk("fetch_align_fault", align_fault, m_af);
      m_af = 1'b0;
      imem_ack = i == wt;
      imem_rdata = i == wt ? data : $urandom;
      @(negedge clock);
    end
    imem_ack = 1'b0;
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst, data);
    chk("hold_opcode", opcode, data[31:26]);
    chk("hold_funct", funct, data[5:0]);
    chk("hold_req", imem_req, 0);
    chk("hold_pc", pc, m_pc);
    chk("hold_align_fault", align_fault, 0);
    for (int s = 0; s < stall; s++) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      control_type = 2'($urandom);
      except = 1'($urandom);
      rs_data = $urandom;
      @(negedge clock);
      chk("stall_inst", inst, data);
      chk("stall_pc", pc, m_pc);
      chk("stall_req", imem_req, 0);
      chk("stall_valid", inst_valid, 1);
    end
    imem_ack = 1'b0;
    inst_ready = 1'b1;
    control_type = ct;
    except = ex;
    rs_data = rs;
    @(negedge clock);
    inst_ready = 1'b0;
    control_type = 2'($urandom);
    except = 1'($urandom);
    rs_data = $urandom;
    model(data, ct, ex, rs);
    chk("next_pc", pc, m_pc);
    chk("next_epc", epc, m_epc);
    chk("next_valid", inst_valid, 0);
  endtask
  initial begin
    v[0]  = '{3, 32'h2008_0005, 0, 2'b00, 1'b0, 32'h0, 32'h0040_0004, 32'h0, 1'b0};
    v[1]  = '{0, 32'h0810_0000, 5, 2'b10, 1'b0, 32'h0, 32'h0040_0000, 32'h0, 1'b0};
    v[2]  = '{1, 32'h0000_0020, 0, 2'b00, 1'b0, 32'h0, 32'h0040_0004, 32'h0, 1'b0};
    v[3]  = '{0, 32'h8C82_0004, 1, 2'b00, 1'b0, 32'h0, 32'h0040_0008, 32'h0, 1'b0};
    v[4]  = '{2, 32'h0810_0000, 0, 2'b10, 1'b1, 32'h0, EXC, 32'h0040_0008, 1'b0};
    v[5]  = '{0, 32'h0320_0008, 0, 2'b11, 1'b0, 32'h0040_0010, 32'h0040_0010, 32'h0040_0008, 1'b0};
    v[6]  = '{1, 32'h1000_FFFF, 2, 2'b01, 1'b0, 32'h0, 32'h0040_0010, 32'h0040_0008, 1'b0};
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    v[7]  = '{0, 32'h0320_0008, 0, 2'b11, 1'b0, 32'h0040_0022, EXC, 32'h0040_0010, 1'b1};
    v[8]  = '{0, 32'h0320_0008, 1, 2'b11, 1'b1, 32'h0040_0023, EXC, EXC, 1'b0};
    v[9]  = '{0, 32'h0320_0008, 0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, EXC, 1'b0};
    v[10] = '{1, 32'h0000_0020, 0, 2'b00, 1'b0, 32'h0, 32'h0, EXC, 1'b0};
    v[11] = '{0, 32'h1000_0010, 0, 2'b01, 1'b0, 32'h0, 32'h0000_0044, EXC, 1'b0};
`else
    v[7]  = '{0, 32'h0320_0008, 0, 2'b11, 1'b0, 32'h0040_0022, 32'h0040_0020, 32'h0040_0008, 1'b0};
    v[8]  = '{0, 32'h0320_0008, 1, 2'b11, 1'b1, 32'h0040_0023, EXC, 32'h0040_0020, 1'b0};
    v[9]  = '{0, 32'h0320_0008, 0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0040_0020, 1'b0};
    v[10] = '{1, 32'h0000_0020, 0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_0020, 1'b0};
    v[11] = '{0, 32'h1000_0010, 0, 2'b01, 1'b0, 32'h0, 32'h0000_0044, 32'h0040_0020, 1'b0};
`endif
    #12;
    chk("reset_pc", pc, RST);
    chk("reset_inst", inst, 0);
    chk("reset_valid", inst_valid, 0);
    chk("reset_epc", epc, 0);
    chk("reset_align_fault", align_fault, 0);
    chk("reset_req", imem_req, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("release_req_before_edge", imem_req, 0);
    @(negedge clock);
    m_pc = RST;
    m_epc = 32'd0;
    m_af = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_instr(v[i].wt, v[i].data, v[i].stall, v[i].ct, v[i].ex, v[i].rs);
      chk("table_pc", pc, v[i].pc_e);
      chk("table_epc", epc, v[i].epc_e);
      chk("table_align_fault", align_fault, v[i].af);
    end
    for (int i = 0; i < 80; i++) begin
      logic [31:0] rs;
      rs = $urandom;
      if ($urandom_range(1, 0) == 1) rs[1:0] = 2'b00;
      run_instr($urandom_range(3, 0), $urandom, $urandom_range(3, 0), 2'($urandom),
                $urandom_range(7, 0) == 0, rs);
    end
    chk("pre_reset_fetch_req", imem_req, 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midfetch_reset_pc", pc, RST);
    chk("midfetch_reset_valid", inst_valid, 0);
    chk("midfetch_reset_req", imem_req, 0);
    chk("midfetch_reset_epc", epc, 0);
    chk("midfetch_reset_align_fault", align_fault, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    @(negedge clock);
    chk("late_ack_inst", inst, 0);
    chk("late_ack_valid", inst_valid, 0);
    imem_ack = 1'b0;
    reset = 1'b1;
    m_pc = RST;
    m_epc = 32'd0;
    m_af = 1'b0;
    @(negedge clock);
    chk("after_reset_inst", inst, 0);
    run_instr(0, 32'h2008_0005, 0, 2'b00, 1'b0, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("prehold_valid", inst_valid, 1);
    #3 reset = 1'b0;
    #1;
    chk("midhold_reset_valid", inst_valid, 0);
    chk("midhold_reset_inst", inst, 0);
    chk("midhold_reset_pc", pc, RST);
    chk("midhold_reset_req", imem_req, 0);
    @(negedge clock);
    reset = 1'b1;
    m_pc = RST;
    m_epc = 32'd0;
    m_af = 1'b0;
    @(negedge clock);
    run_instr(1, 32'h1000_FFFF, 1, 2'b01, 1'b0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
